// File: rtl/combo_lock_pkg.sv
// Shared state encoding and helpers for the parametrised combination lock.
package combo_lock_pkg;

   typedef enum logic [2:0] {
      ST_LOCKED  = 3'd0,
      ST_CHECK   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_PROG    = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_e;

   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/combo_lock_param_btn_press_enc.sv
// Button rising-edge detector with one-hot validation and binary symbol encoder.
module btn_press_enc
   import combo_lock_pkg::*;
#(
   parameter int NUM_BTN = 4,
   parameter int SYM_W   = 2
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [NUM_BTN-1:0] btn,
   output logic               press_vld,
   output logic [SYM_W-1:0]   press_sym,
   output logic               multi_err
);

   logic [NUM_BTN-1:0] btn_q;
   logic [NUM_BTN-1:0] rise_s;

   // Previous button levels for edge detection.
   always_ff @(posedge clk) begin
      if (clr) begin
         btn_q <= '0;
      end else begin
         btn_q <= btn;
      end
   end

   assign rise_s = btn & ~btn_q;

   // A press only counts when exactly one button rose and no other is held.
   always_comb begin
      press_vld = is_onehot(32'(rise_s)) && is_onehot(32'(btn));
      multi_err = (|rise_s) && !is_onehot(32'(btn));
      press_sym = '0;
      for (int k = 0; k < NUM_BTN; k++) begin
         press_sym = press_sym | (rise_s[k] ? SYM_W'(k) : '0);
      end
   end

endmodule

// File: rtl/combo_lock_param.sv
// Parametrised keypad combination lock: entry FSM, key storage, fail counter and lockout timer.
module combo_lock_param
   import combo_lock_pkg::*;
#(
   parameter int NUM_BTN     = 4,
   parameter int CODE_LEN    = 4,
   parameter int MAX_FAIL    = 3,
   parameter int LOCKOUT_CYC = 1024,
   parameter logic [CODE_LEN*$clog2(NUM_BTN)-1:0] DEFAULT_KEY = 8'hE4
) (
   input  logic                            clk,
   input  logic                            clr,
   input  logic [NUM_BTN-1:0]              btn,
   input  logic                            re,
   output logic                            unlocked,
   output logic                            reprog,
   output logic                            locked_out,
   output logic                            err,
   output logic [$clog2(CODE_LEN+1)-1:0]   entry_cnt,
   output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

   localparam int SYM_W = $clog2(NUM_BTN);
   localparam int KEY_W = CODE_LEN * SYM_W;
   localparam int CW    = $clog2(CODE_LEN + 1);
   localparam int FW    = $clog2(MAX_FAIL + 1);
   localparam int TW    = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

   state_e             state_q, state_d;
   logic [KEY_W-1:0]   guess_q, guess_d;
   logic [KEY_W-1:0]   stage_q, stage_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [CW-1:0]      entry_q, entry_d;
   logic [FW-1:0]      fail_q, fail_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               re_q;
   logic               unlocked_q, reprog_q, locked_out_q, err_q;
   logic               press_vld;
   logic [SYM_W-1:0]   press_sym;
   logic               multi_err;
   logic               re_rise_s;
   logic               last_s;

   btn_press_enc #(
      .NUM_BTN (NUM_BTN),
      .SYM_W   (SYM_W)
   ) u_enc (
      .clk       (clk),
      .clr       (clr),
      .btn       (btn),
      .press_vld (press_vld),
      .press_sym (press_sym),
      .multi_err (multi_err)
   );

   assign re_rise_s = re & ~re_q;
   assign last_s    = (entry_q == CW'(CODE_LEN - 1));

   // State and datapath registers; status outputs follow the next state so they align with it.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q      <= ST_LOCKED;
         guess_q      <= '0;
         stage_q      <= '0;
         key_q        <= DEFAULT_KEY;
         entry_q      <= '0;
         fail_q       <= '0;
         timer_q      <= '0;
         re_q         <= 1'b0;
         unlocked_q   <= 1'b0;
         reprog_q     <= 1'b0;
         locked_out_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         guess_q      <= guess_d;
         stage_q      <= stage_d;
         key_q        <= key_d;
         entry_q      <= entry_d;
         fail_q       <= fail_d;
         timer_q      <= timer_d;
         re_q         <= re;
         unlocked_q   <= (state_d == ST_OPEN);
         reprog_q     <= (state_d == ST_PROG);
         locked_out_q <= (state_d == ST_LOCKOUT);
         err_q        <= multi_err;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      guess_d = guess_q;
      stage_d = stage_q;
      key_d   = key_q;
      entry_d = entry_q;
      fail_d  = fail_q;
      timer_d = timer_q;
      case (state_q)
         ST_LOCKED: begin
            if (press_vld) begin
               guess_d[int'(entry_q)*SYM_W +: SYM_W] = press_sym;
               entry_d = entry_q + CW'(1);
               state_d = last_s ? ST_CHECK : ST_LOCKED;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         ST_CHECK: begin
            entry_d = '0;
            guess_d = '0;
            if (guess_q == key_q) begin
               state_d = ST_OPEN;
               fail_d  = '0;
            end else if (fail_q == FW'(MAX_FAIL - 1)) begin
               state_d = ST_LOCKOUT;
               timer_d = TW'(LOCKOUT_CYC - 1);
               fail_d  = FW'(MAX_FAIL);
            end else begin
               state_d = ST_LOCKED;
               fail_d  = fail_q + FW'(1);
            end
         end
         ST_OPEN: begin
            if (re_rise_s) begin
               state_d = ST_PROG;
               entry_d = '0;
               stage_d = '0;
            end else if (press_vld) begin
               state_d = ST_LOCKED;
            end else begin
               state_d = ST_OPEN;
            end
         end
         ST_PROG: begin
            // Abort takes priority over a simultaneous press.
            if (re_rise_s) begin
               state_d = ST_OPEN;
               entry_d = '0;
               stage_d = '0;
            end else if (press_vld) begin
               stage_d[int'(entry_q)*SYM_W +: SYM_W] = press_sym;
               if (last_s) begin
                  key_d   = stage_d;
                  stage_d = '0;
                  entry_d = '0;
                  state_d = ST_LOCKED;
               end else begin
                  entry_d = entry_q + CW'(1);
               end
            end else begin
               state_d = ST_PROG;
            end
         end
         ST_LOCKOUT: begin
            if (timer_q == '0) begin
               state_d = ST_LOCKED;
               fail_d  = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: begin
            state_d = ST_LOCKED;
         end
      endcase
   end

   assign unlocked   = unlocked_q;
   assign reprog     = reprog_q;
   assign locked_out = locked_out_q;
   assign err        = err_q;
   assign entry_cnt  = entry_q;
   assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed self-checking bench for combo_lock_param with a 16-cycle lockout.
module tb_combo_lock_param;

   logic       clk = 1'b0;
   logic       clr;
   logic [3:0] btn;
   logic       re;
   logic       unlocked, reprog, locked_out, err;
   logic [2:0] entry_cnt;
   logic [1:0] fail_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   combo_lock_param #(
      .NUM_BTN     (4),
      .CODE_LEN    (4),
      .MAX_FAIL    (3),
      .LOCKOUT_CYC (16),
      .DEFAULT_KEY (8'hE4)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .btn        (btn),
      .re         (re),
      .unlocked   (unlocked),
      .reprog     (reprog),
      .locked_out (locked_out),
      .err        (err),
      .entry_cnt  (entry_cnt),
      .fail_cnt   (fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input int k);
      btn = 4'b0001 << k;
      @(negedge clk);
      btn = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic do_code(input int a, input int b, input int c, input int d);
      press(a);
      press(b);
      press(c);
      press(d);
   endtask

   task automatic pulse_re();
      re = 1'b1;
      @(negedge clk);
      re = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      clr = 1'b1;
      btn = 4'b0000;
      re  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("rst_outs", {26'd0, unlocked, reprog, locked_out, err, entry_cnt == 3'd0, fail_cnt == 2'd0},
                32'h0000_0003);
      clr = 1'b0;

      // 1: correct default code, with exact unlock latency
      for (int i = 0; i < 3; i++) begin
         btn = 4'b0001 << i;
         @(negedge clk);
         check_val("t1_entry", 32'(entry_cnt), 32'(i + 1));
         btn = 4'b0000;
         @(negedge clk);
         @(negedge clk);
      end
      btn = 4'b1000;
      @(negedge clk);
      check_val("t1_entry4", 32'(entry_cnt), 32'd4);
      check_val("t1_not_yet", 32'(unlocked), 32'd0);
      btn = 4'b0000;
      @(negedge clk);
      check_val("t1_unlocked", 32'(unlocked), 32'd1);
      check_val("t1_fail", 32'(fail_cnt), 32'd0);
      @(negedge clk);

      // 2: three wrong codes -> lockout
      press(0);
      check_val("t2_relock", {30'd0, unlocked, entry_cnt == 3'd0}, 32'd1);
      do_code(0, 0, 0, 0);
      check_val("t2_fail1", 32'(fail_cnt), 32'd1);
      do_code(0, 0, 0, 0);
      check_val("t2_fail2", 32'(fail_cnt), 32'd2);
      check_val("t2_nolock", 32'(locked_out), 32'd0);
      press(0);
      press(0);
      press(0);
      btn = 4'b0001;
      @(negedge clk);
      check_val("t2_check_cyc", 32'(locked_out), 32'd0);
      btn = 4'b0000;
      @(negedge clk);
      check_val("t2_fail3", 32'(fail_cnt), 32'd3);
      cnt = 0;
      while (locked_out && cnt < 40) begin
         cnt++;
         btn = cnt[0] ? 4'b0100 : 4'b0000;
         @(negedge clk);
      end
      btn = 4'b0000;
      check_val("t2_lock_len", 32'(cnt), 32'd16);
      check_val("t2_entry_lo", 32'(entry_cnt), 32'd0);
      check_val("t2_fail_clr", 32'(fail_cnt), 32'd0);
      check_val("t2_locked", {30'd0, unlocked, locked_out}, 32'd0);
      @(negedge clk);

      // 3: reprogram to all-3s
      do_code(0, 1, 2, 3);
      check_val("t3_open", 32'(unlocked), 32'd1);
      re = 1'b1;
      @(negedge clk);
      check_val("t3_reprog", 32'(reprog), 32'd1);
      re = 1'b0;
      @(negedge clk);
      do_code(3, 3, 3, 3);
      check_val("t3_prog_done", {30'd0, reprog, unlocked}, 32'd0);
      do_code(0, 1, 2, 3);
      check_val("t3_old_fails", 32'(fail_cnt), 32'd1);
      check_val("t3_old_closed", 32'(unlocked), 32'd0);
      do_code(3, 3, 3, 3);
      check_val("t3_new_opens", 32'(unlocked), 32'd1);

      // 4: multi-button error and held button
      press(0);
      btn = 4'b0011;
      @(negedge clk);
      check_val("t4_err", 32'(err), 32'd1);
      check_val("t4_err_entry", 32'(entry_cnt), 32'd0);
      btn = 4'b0000;
      @(negedge clk);
      check_val("t4_err_pulse", 32'(err), 32'd0);
      btn = 4'b0010;
      for (int i = 0; i < 10; i++) @(negedge clk);
      btn = 4'b0000;
      @(negedge clk);
      check_val("t4_held", 32'(entry_cnt), 32'd1);

      // 5: re handling
      pulse_re();
      check_val("t5_re_locked", {29'd0, reprog, entry_cnt}, 32'd1);
      press(3);
      press(3);
      press(3);
      check_val("t5_bad_guess", 32'(fail_cnt), 32'd1);
      do_code(3, 3, 3, 3);
      check_val("t5_open", 32'(unlocked), 32'd1);
      re = 1'b1;
      @(negedge clk);
      re = 1'b0;
      press(0);
      press(1);
      check_val("t5_prog2", {29'd0, reprog, entry_cnt}, 32'h0000_000A);
      re = 1'b1;
      @(negedge clk);
      check_val("t5_abort", {28'd0, unlocked, reprog, entry_cnt == 3'd0, 1'b0}, 32'h0000_000A);
      re = 1'b0;
      @(negedge clk);
      press(2);
      do_code(3, 3, 3, 3);
      check_val("t5_key_kept", 32'(unlocked), 32'd1);
      re  = 1'b1;
      btn = 4'b0100;
      @(negedge clk);
      check_val("t5_same_cyc", {28'd0, reprog, unlocked, entry_cnt == 3'd0, 1'b0}, 32'h0000_000A);
      re  = 1'b0;
      btn = 4'b0000;
      @(negedge clk);

      // 6: synchronous clear mid-sequence
      press(0);
      press(1);
      pulse_clr();
      check_val("t6_clr_prog", {29'd0, reprog, entry_cnt == 3'd0, 1'b0}, 32'd2);
      press(0);
      press(1);
      check_val("t6_entry2", 32'(entry_cnt), 32'd2);
      pulse_clr();
      check_val("t6_clr_entry", 32'(entry_cnt), 32'd0);
      do_code(3, 3, 3, 3);
      check_val("t6_ff_fails", 32'(fail_cnt), 32'd1);
      do_code(0, 1, 2, 3);
      check_val("t6_open", 32'(unlocked), 32'd1);
      pulse_re();
      do_code(3, 3, 3, 3);
      check_val("t6_prog_ff", {30'd0, reprog, unlocked}, 32'd0);
      pulse_clr();
      do_code(0, 1, 2, 3);
      check_val("t6_default", 32'(unlocked), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
